l4_demux8_ser2par: RTL

L4_DEMUX8_SER2PAR -- requirements
Module: l4_demux8_ser2par

---
 rtl/l4_demux8_ser2par.sv | 116 +++++++++++
 1 files changed

// File: rtl/l4_demux8_ser2par.sv
`default_nettype none
// ============================================================================
// Module      : l4_demux8_ser2par
// Description : 1:8 word demux; packs a word stream into eight slot registers
//               and holds the frame until the consumer acknowledges it.
// Revision    : 1.0 - initial release
// ============================================================================
module l4_demux8_ser2par #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] din,
    input  logic             in_last,
    output logic [NBITS-1:0] out0,
    output logic [NBITS-1:0] out1,
    output logic [NBITS-1:0] out2,
    output logic [NBITS-1:0] out3,
    output logic [NBITS-1:0] out4,
    output logic [NBITS-1:0] out5,
    output logic [NBITS-1:0] out6,
    output logic [NBITS-1:0] out7,
    output logic             out_valid,
    output logic [3:0]       out_cnt,
    input  logic             out_ack
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    localparam logic [2:0] c_LAST_IDX = 3'd7;

    state_t           r_state_q, w_state_d;
    logic [2:0]       r_idx_q,   w_idx_d;
    logic [3:0]       r_cnt_q,   w_cnt_d;
    logic [NBITS-1:0] r_slot_q [8];
    logic [NBITS-1:0] w_slot_d [8];
    logic             w_accept;

    assign w_accept = in_valid && (r_state_q == ST_FILL);

    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        w_cnt_d   = r_cnt_q;
        for (int k = 0; k < 8; k++) begin
            w_slot_d[k] = r_slot_q[k];
        end

        case (r_state_q)
            ST_FILL: begin
                if (w_accept) begin
                    w_slot_d[r_idx_q] = din;
                    w_idx_d           = r_idx_q + 3'd1;
                    // Frame closes on the 8th word or on in_last, whichever first
                    if (r_idx_q == c_LAST_IDX || in_last) begin
                        w_state_d = ST_FULL;
                        w_cnt_d   = {1'b0, r_idx_q} + 4'd1;
                        w_idx_d   = 3'd0;
                    end
                end
            end
            ST_FULL: begin
                if (out_ack) begin
                    w_state_d = ST_FILL;
                    w_idx_d   = 3'd0;
                    w_cnt_d   = 4'd0;
                    for (int k = 0; k < 8; k++) begin
                        w_slot_d[k] = '0;
                    end
                end
            end
            default: begin
                w_state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_FILL;
            r_idx_q   <= 3'd0;
            r_cnt_q   <= 4'd0;
            for (int k = 0; k < 8; k++) begin
                r_slot_q[k] <= '0;
            end
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_cnt_q   <= w_cnt_d;
            for (int k = 0; k < 8; k++) begin
                r_slot_q[k] <= w_slot_d[k];
            end
        end
    end

    // Handshake outputs decode the state register only
    assign in_ready  = (r_state_q == ST_FILL);
    assign out_valid = (r_state_q == ST_FULL);
    assign out_cnt   = r_cnt_q;

    assign out0 = r_slot_q[0];
    assign out1 = r_slot_q[1];
    assign out2 = r_slot_q[2];
    assign out3 = r_slot_q[3];
    assign out4 = r_slot_q[4];
    assign out5 = r_slot_q[5];
    assign out6 = r_slot_q[6];
    assign out7 = r_slot_q[7];

endmodule
`default_nettype wire
